// File: rtl/wb_stage.sv
// Writeback stage: commits ALU results into a 16x32 register file and the CPSR flags.
// Define WB_BYPASS_EN to forward in-flight COMMIT writes onto the decoder read ports.
module wb_stage #(
   parameter int DATA_W      = 32,
   parameter int NREGS       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] dataIn1,
   input  logic [DATA_W-1:0] dataIn2,
   input  logic [DATA_W-1:0] cpsrIn,
   input  logic              wIn,
   input  logic [DATA_W-1:0] srcDstIn,
   input  logic              readyIn,
   output logic              triggerOut,
   input  logic [3:0]        rdAddr1,
   input  logic [3:0]        rdAddr2,
   output logic [DATA_W-1:0] rdData1,
   output logic [DATA_W-1:0] rdData2,
   output logic [DATA_W-1:0] cpsrOut,
   output logic [15:0]       commitCount,
   output logic              busy
);

   typedef enum logic [2:0] {
      ST_START,
      ST_WAIT_LOW,
      ST_WAIT_HIGH,
      ST_CAPTURE,
      ST_COMMIT
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic                     capture_en;
   logic                     commit_en;
   logic                     toggle_en;

   logic [SYNC_STAGES-1:0]   sync_q;
   logic                     rdy_sync;

   logic [DATA_W-1:0]        hold_data1;
   logic [DATA_W-1:0]        hold_data2;
   logic [3:0]               hold_flags;
   logic                     hold_w;
   logic [3:0]               hold_rd1;
   logic [3:0]               hold_rd2;
   logic                     hold_wr2;
   logic                     hold_upd;

   logic [DATA_W-1:0]        regs [NREGS];
   logic [3:0]               flags;
   logic                     trigger;
   logic [15:0]              count;

   logic                     unused_bits;
   assign unused_bits = ^{cpsrIn[DATA_W-5:0], srcDstIn[DATA_W-1:10]};

   // readyIn is an unclocked level from the ALU; only rdy_sync may steer the FSM
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], readyIn};
      end
   end
   assign rdy_sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_START;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      capture_en = 1'b0;
      commit_en  = 1'b0;
      toggle_en  = 1'b0;
      busy       = 1'b0;
      case (state)
         ST_START: begin
            toggle_en = 1'b1;
            state_nxt = ST_WAIT_LOW;
         end
         ST_WAIT_LOW: begin
            if (!rdy_sync) state_nxt = ST_WAIT_HIGH;
         end
         ST_WAIT_HIGH: begin
            if (rdy_sync) state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            capture_en = 1'b1;
            busy       = 1'b1;
            state_nxt  = ST_COMMIT;
         end
         ST_COMMIT: begin
            commit_en  = 1'b1;
            toggle_en  = 1'b1;
            busy       = 1'b1;
            state_nxt  = ST_WAIT_LOW;
         end
         default: state_nxt = ST_START;
      endcase
   end

   // Holding registers carry no reset: a reset returns the FSM to START, so they are never committed
   always_ff @(posedge clk) begin
      if (capture_en) begin
         hold_data1 <= dataIn1;
         hold_data2 <= dataIn2;
         hold_flags <= cpsrIn[DATA_W-1 -: 4];
         hold_w     <= wIn;
         hold_rd1   <= srcDstIn[3:0];
         hold_rd2   <= srcDstIn[7:4];
         hold_wr2   <= srcDstIn[8];
         hold_upd   <= srcDstIn[9];
      end
   end

   // Rd1 write is issued after Rd2 so data1 wins when both target the same register
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         flags   <= '0;
         trigger <= 1'b0;
         count   <= '0;
      end else begin
         if (toggle_en) trigger <= ~trigger;
         if (commit_en) begin
            if (hold_wr2) regs[hold_rd2] <= hold_data2;
            if (hold_w)   regs[hold_rd1] <= hold_data1;
            if (hold_upd) flags <= hold_flags;
            count <= count + 16'd1;
         end
      end
   end

   always_comb begin
      rdData1 = regs[rdAddr1];
      rdData2 = regs[rdAddr2];
`ifdef WB_BYPASS_EN
      if (commit_en) begin
         if (hold_wr2 && rdAddr1 == hold_rd2) rdData1 = hold_data2;
         if (hold_w   && rdAddr1 == hold_rd1) rdData1 = hold_data1;
         if (hold_wr2 && rdAddr2 == hold_rd2) rdData2 = hold_data2;
         if (hold_w   && rdAddr2 == hold_rd1) rdData2 = hold_data1;
      end
`endif
   end

   assign cpsrOut     = {flags, {(DATA_W-4){1'b0}}};
   assign triggerOut  = trigger;
   assign commitCount = count;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level register/CPSR model.
module tb_wb_stage;

   localparam int DATA_W = 32;
   localparam int SYNC   = 2;
`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] dataIn1, dataIn2, cpsrIn, srcDstIn;
   logic              wIn, readyIn;
   logic              triggerOut;
   logic [3:0]        rdAddr1, rdAddr2;
   logic [DATA_W-1:0] rdData1, rdData2, cpsrOut;
   logic [15:0]       commitCount;
   logic              busy;

   always #5 clk = ~clk;

   wb_stage #(.DATA_W(DATA_W), .NREGS(16), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset(reset),
      .dataIn1(dataIn1), .dataIn2(dataIn2), .cpsrIn(cpsrIn), .wIn(wIn),
      .srcDstIn(srcDstIn), .readyIn(readyIn), .triggerOut(triggerOut),
      .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdData1(rdData1), .rdData2(rdData2),
      .cpsrOut(cpsrOut), .commitCount(commitCount), .busy(busy)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m_regs [16];
   logic [3:0]  m_flags;
   logic [15:0] m_cnt;
   logic        m_trig;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_flags = '0;
      m_cnt   = '0;
      m_trig  = 1'b0;
   endtask

   function automatic logic [31:0] exp_read(input logic [3:0] a, input logic [31:0] d1,
                                            input logic [31:0] d2, input logic w,
                                            input logic [31:0] sd);
      if (BYPASS && w && a == sd[3:0]) return d1;
      if (BYPASS && sd[8] && a == sd[7:4]) return d2;
      return m_regs[a];
   endfunction

   task automatic do_txn(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] cpsr,
                         input logic w, input logic [31:0] sd, input string tag);
      logic [3:0] rd1, rd2;
      rd1 = sd[3:0];
      rd2 = sd[7:4];
      readyIn = 1'b0;
      repeat (SYNC + 2) tick();
      dataIn1 = d1; dataIn2 = d2; cpsrIn = cpsr; wIn = w; srcDstIn = sd;
      rdAddr1 = rd1; rdAddr2 = rd2;
      readyIn = 1'b1;
      repeat (SYNC + 2) tick();
      // COMMIT cycle: registers not yet written, trigger not yet toggled
      check({tag, " busy_commit"}, 32'(busy), 32'd1);
      check({tag, " trig_hold"}, 32'(triggerOut), 32'(m_trig));
      check({tag, " rd1_in_commit"}, rdData1, exp_read(rd1, d1, d2, w, sd));
      check({tag, " rd2_in_commit"}, rdData2, exp_read(rd2, d1, d2, w, sd));
      dataIn1 = $urandom; dataIn2 = $urandom; cpsrIn = $urandom;
      wIn = ~w; srcDstIn = $urandom;
      tick();
      if (sd[8]) m_regs[rd2] = d2;
      if (w)     m_regs[rd1] = d1;
      if (sd[9]) m_flags = cpsr[31:28];
      m_cnt  = m_cnt + 16'd1;
      m_trig = ~m_trig;
      check({tag, " trig"}, 32'(triggerOut), 32'(m_trig));
      check({tag, " count"}, 32'(commitCount), 32'(m_cnt));
      check({tag, " cpsr"}, cpsrOut, {m_flags, 28'd0});
      check({tag, " busy_after"}, 32'(busy), 32'd0);
      check({tag, " rd1"}, rdData1, m_regs[rd1]);
      check({tag, " rd2"}, rdData2, m_regs[rd2]);
   endtask

   initial begin
      reset = 1'b0; readyIn = 1'b0; wIn = 1'b0;
      dataIn1 = '0; dataIn2 = '0; cpsrIn = '0; srcDstIn = '0;
      rdAddr1 = 4'd3; rdAddr2 = 4'd15;
      model_reset();
      repeat (3) tick();
      check("rst trig", 32'(triggerOut), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst count", 32'(commitCount), 32'd0);
      check("rst cpsr", cpsrOut, 32'd0);
      check("rst rd1", rdData1, 32'd0);

      reset = 1'b1;
      tick();
      m_trig = 1'b1;
      check("start trig", 32'(triggerOut), 32'(m_trig));
      for (int a = 0; a < 16; a++) begin
         rdAddr1 = 4'(a);
         rdAddr2 = 4'(15 - a);
         #1;
         check("init rd1", rdData1, 32'd0);
         check("init rd2", rdData2, 32'd0);
      end

      do_txn(32'h0000_00A5, 32'h0, 32'h0, 1'b1, 32'h3, "a5");
      do_txn(32'h0, 32'h0, 32'h6000_0000, 1'b0, 32'h200, "cmp");
      do_txn(32'h11, 32'h22, 32'h0, 1'b1, 32'h155, "dual");

      // readyIn never drops: no new operation may start
      repeat (12) tick();
      check("held count", 32'(commitCount), 32'(m_cnt));
      check("held trig", 32'(triggerOut), 32'(m_trig));
      check("held busy", 32'(busy), 32'd0);

      for (int n = 0; n < 30; n++) begin
         do_txn($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 1023)), "rand");
      end

      // reset while in CAPTURE abandons the pending result
      readyIn = 1'b0;
      repeat (SYNC + 2) tick();
      dataIn1 = 32'hDEAD; wIn = 1'b1; srcDstIn = 32'h7; rdAddr1 = 4'd7;
      readyIn = 1'b1;
      repeat (SYNC + 1) tick();
      check("capture busy", 32'(busy), 32'd1);
      reset = 1'b0;
      readyIn = 1'b0;
      tick();
      model_reset();
      check("midrst trig", 32'(triggerOut), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b1;
      tick();
      m_trig = 1'b1;
      check("restart trig", 32'(triggerOut), 32'(m_trig));
      check("restart count", 32'(commitCount), 32'd0);
      check("restart reg7", rdData1, 32'd0);

      do_txn(32'h1234, 32'h0, 32'h0, 1'b1, 32'h7, "pre7");
      do_txn(32'hBEEF, 32'h0, 32'hF000_0000, 1'b1, 32'h7, "beef");

      for (int a = 0; a < 16; a++) begin
         rdAddr1 = 4'(a);
         #1;
         check("sweep", rdData1, m_regs[a]);
      end
      check("final cpsr", cpsrOut, {m_flags, 28'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
